multi_anti_rebote: RTL and testbench



---
 rtl/multi_anti_rebote_if.sv | 27 ++
 rtl/multi_anti_rebote.sv | 79 +++++++
 tb/tb_multi_anti_rebote.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_anti_rebote_if.sv
// Pin-side bundle of the multi-channel debouncer:
// raw levels in, clean levels, edge pulses and sample strobe out.
interface multi_anti_rebote_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] D;
    logic [N_CH-1:0] DA;
    logic [N_CH-1:0] RISE;
    logic [N_CH-1:0] FALL;
    logic            TICK;

    modport master (
        output D,
        input  DA,
        input  RISE,
        input  FALL,
        input  TICK
    );

    modport slave (
        input  D,
        output DA,
        output RISE,
        output FALL,
        output TICK
    );
endinterface

// File: rtl/multi_anti_rebote.sv
// Multi-channel debouncer: 2-flop synchronisers, shared sample prescaler,
// per-channel stable-count filter with registered rise/fall pulses.
module multi_anti_rebote #(
    parameter int N_CH     = 4,
    parameter int STABLE   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    multi_anti_rebote_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [PW-1:0] PC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE - 1);

    logic [N_CH-1:0] s1;
    logic [N_CH-1:0] s2;
    logic [N_CH-1:0] da;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [PW-1:0]   pc;
    logic            tick;
    logic [CW-1:0]   cnt [N_CH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.D;
            s2 <= s1;
        end
    end

    // tick is registered so it stays low through reset even when TICK_DIV=1
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc   <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pc == PC_LAST);
            pc   <= (pc == PC_LAST) ? '0 : pc + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            da   <= '0;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            if (tick) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (s2[i] == da[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        da[i]   <= s2[i];
                        rise[i] <= s2[i];
                        fall[i] <= ~s2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.DA   = da;
    assign bus.RISE = rise;
    assign bus.FALL = fall;
    assign bus.TICK = tick;
endmodule

// File: tb/tb_multi_anti_rebote.sv
// Directed bench for multi_anti_rebote: three configurations on one clock,
// expected outputs queued with their due edge and checked as edges pass.
module tb_multi_anti_rebote;
    typedef struct {
        int         at;
        int         sel;
        string      tag;
        logic [3:0] da;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       tick;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   ntests;
    int   nfail;
    int   r;
    exp_t q[$];

    multi_anti_rebote_if #(.N_CH(4)) ia ();
    multi_anti_rebote_if #(.N_CH(4)) ib ();
    multi_anti_rebote_if #(.N_CH(4)) ic ();

    multi_anti_rebote #(.N_CH(4), .STABLE(4), .TICK_DIV(1)) ua (
        .CLK(clk), .RST(rst), .bus(ia)
    );
    multi_anti_rebote #(.N_CH(4), .STABLE(4), .TICK_DIV(3)) ub (
        .CLK(clk), .RST(rst), .bus(ib)
    );
    multi_anti_rebote #(.N_CH(4), .STABLE(1), .TICK_DIV(1)) uc (
        .CLK(clk), .RST(rst), .bus(ic)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got,
                       input logic [3:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic push(input int at, input int sel, input string tag,
                        input logic [3:0] da, input logic [3:0] rise,
                        input logic [3:0] fall, input logic tick);
        exp_t e;
        e.at = at; e.sel = sel; e.tag = tag;
        e.da = da; e.rise = rise; e.fall = fall; e.tick = tick;
        q.push_back(e);
    endtask

    task automatic check_due();
        exp_t e;
        logic [3:0] gda, grise, gfall;
        logic gtick;
        while (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            case (e.sel)
                0: begin gda = ia.DA; grise = ia.RISE; gfall = ia.FALL; gtick = ia.TICK; end
                1: begin gda = ib.DA; grise = ib.RISE; gfall = ib.FALL; gtick = ib.TICK; end
                default: begin gda = ic.DA; grise = ic.RISE; gfall = ic.FALL; gtick = ic.TICK; end
            endcase
            chk({e.tag, "_da"}, gda, e.da);
            chk({e.tag, "_rise"}, grise, e.rise);
            chk({e.tag, "_fall"}, gfall, e.fall);
            chk({e.tag, "_tick"}, {3'b0, gtick}, {3'b0, e.tick});
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        check_due();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (q.size() > 0 && n < limit) begin
            step();
            n++;
        end
        ntests++;
        assert (q.size() == 0) else begin
            nfail++;
            $error("FAIL drain_timeout got=%0d pending exp=0", q.size());
        end
        q.delete();
    endtask

    initial begin
        int k;
        int e;
        int n;
        cyc = 0; ntests = 0; nfail = 0;
        rst = 1'b1;
        ia.D = 4'hF; ib.D = 4'hF; ic.D = 4'hF;
        repeat (5) step();
        chk("rst_da_a", ia.DA, 4'h0);
        chk("rst_rise_a", ia.RISE, 4'h0);
        chk("rst_tick_a", {3'b0, ia.TICK}, 4'h0);
        chk("rst_tick_b", {3'b0, ib.TICK}, 4'h0);

        rst = 1'b0;
        repeat (3) step();
        chk("count_da_a", ia.DA, 4'h0);
        chk("pre_rst_da_c", ic.DA, 4'hF);
        chk("pre_rst_rise_c", ic.RISE, 4'hF);
        #2 rst = 1'b1;
        #1;
        chk("async_da_a", ia.DA, 4'h0);
        chk("async_da_c", ic.DA, 4'h0);
        chk("async_rise_c", ic.RISE, 4'h0);
        chk("async_tick_a", {3'b0, ia.TICK}, 4'h0);
        chk("async_tick_c", {3'b0, ic.TICK}, 4'h0);
        repeat (2) step();
        chk("held_da_c", ic.DA, 4'h0);
        chk("held_tick_a", {3'b0, ia.TICK}, 4'h0);

        ia.D = 4'h0; ib.D = 4'h0; ic.D = 4'h0;
        repeat (3) step();
        rst = 1'b0;
        r = cyc;
        repeat (9) begin
            step();
            chk("tick_b", {3'b0, ib.TICK}, {3'b0, ((cyc - r) % 3 == 0)});
            chk("tick_a", {3'b0, ia.TICK}, 4'h1);
        end

        k = cyc + 1;
        push(k + 4, 0, "a_rise_pre", 4'h0, 4'h0, 4'h0, 1'b1);
        push(k + 5, 0, "a_rise", 4'h1, 4'h1, 4'h0, 1'b1);
        push(k + 6, 0, "a_rise_post", 4'h1, 4'h0, 4'h0, 1'b1);
        ia.D[0] = 1'b1;
        drain(40);

        k = cyc + 1;
        push(k + 4, 0, "a_fall_pre", 4'h1, 4'h0, 4'h0, 1'b1);
        push(k + 5, 0, "a_fall", 4'h0, 4'h0, 4'h1, 1'b1);
        push(k + 6, 0, "a_fall_post", 4'h0, 4'h0, 4'h0, 1'b1);
        ia.D[0] = 1'b0;
        drain(40);

        for (int i = 0; i < 10; i++) begin
            ia.D[1] = (i % 2 == 0);
            repeat (2) begin
                step();
                chk("bounce_rise", {3'b0, ia.RISE[1]}, 4'h0);
            end
        end
        chk("bounce_da", ia.DA, 4'h0);
        k = cyc + 1;
        push(k + 4, 0, "settle_pre", 4'h0, 4'h0, 4'h0, 1'b1);
        push(k + 5, 0, "settle", 4'h2, 4'h2, 4'h0, 1'b1);
        push(k + 6, 0, "settle_post", 4'h2, 4'h0, 4'h0, 1'b1);
        ia.D[1] = 1'b1;
        drain(40);

        k = cyc + 1;
        push(k + 5, 0, "prep", 4'h4, 4'h4, 4'h2, 1'b1);
        ia.D[1] = 1'b0;
        ia.D[2] = 1'b1;
        drain(40);

        k = cyc + 1;
        push(k + 4, 0, "simul_pre", 4'h4, 4'h0, 4'h0, 1'b1);
        push(k + 5, 0, "simul", 4'h8, 4'h8, 4'h4, 1'b1);
        push(k + 6, 0, "simul_post", 4'h8, 4'h0, 4'h0, 1'b1);
        ia.D[2] = 1'b0;
        ia.D[3] = 1'b1;
        drain(40);

        e = cyc + 2;
        n = 0;
        while (n < 4) begin
            e++;
            if ((e - r - 1) % 3 == 0) n++;
        end
        push(e - 1, 1, "b_rise_pre", 4'h0, 4'h0, 4'h0, 1'b1);
        push(e, 1, "b_rise", 4'h1, 4'h1, 4'h0, 1'b0);
        push(e + 1, 1, "b_rise_post", 4'h1, 4'h0, 4'h0, 1'b0);
        ib.D[0] = 1'b1;
        drain(60);

        k = cyc + 1;
        push(k + 1, 2, "c_rise_pre", 4'h0, 4'h0, 4'h0, 1'b1);
        push(k + 2, 2, "c_rise", 4'h1, 4'h1, 4'h0, 1'b1);
        push(k + 3, 2, "c_rise_post", 4'h1, 4'h0, 4'h0, 1'b1);
        ic.D[0] = 1'b1;
        drain(20);

        k = cyc + 1;
        push(k + 2, 2, "c_glitch_fall", 4'h0, 4'h0, 4'h1, 1'b1);
        push(k + 3, 2, "c_glitch_rise", 4'h1, 4'h1, 4'h0, 1'b1);
        push(k + 4, 2, "c_glitch_post", 4'h1, 4'h0, 4'h0, 1'b1);
        ic.D[0] = 1'b0;
        step();
        ic.D[0] = 1'b1;
        drain(20);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
